// File: rtl/bnn_pkg.sv
// Shared constants and types for the FC classifier stage.
// Lane count, score width, the most negative score and the argmax sequencer states.
package bnn_pkg;

    localparam int FC_LANES = 10;
    localparam int FC_SW    = 10;
    localparam int IDX_W    = 4;

    localparam logic signed [FC_SW-1:0] SCORE_MIN = 10'sh200;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fc_argmax_seq_if.sv
// FC score input strobe and classifier result handshake bundle.
// The master side is the score producer / result consumer; the slave side is the argmax stage.
interface fc_argmax_seq_if
    import bnn_pkg::*;
#(
    parameter int SW = FC_SW
);
    logic                 in_valid;
    logic signed [SW-1:0] fc_result_0;
    logic signed [SW-1:0] fc_result_1;
    logic signed [SW-1:0] fc_result_2;
    logic signed [SW-1:0] fc_result_3;
    logic signed [SW-1:0] fc_result_4;
    logic signed [SW-1:0] fc_result_5;
    logic signed [SW-1:0] fc_result_6;
    logic signed [SW-1:0] fc_result_7;
    logic signed [SW-1:0] fc_result_8;
    logic signed [SW-1:0] fc_result_9;
    logic                 out_ready;
    logic                 out_valid;
    logic [9:0]           classes;
    logic [3:0]           classes_b;
    logic signed [SW-1:0] max_score;
    logic [SW:0]          margin;
    logic                 busy;
    logic                 overrun;

    modport master (
        output in_valid, fc_result_0, fc_result_1, fc_result_2, fc_result_3, fc_result_4,
               fc_result_5, fc_result_6, fc_result_7, fc_result_8, fc_result_9, out_ready,
        input  out_valid, classes, classes_b, max_score, margin, busy, overrun
    );

    modport slave (
        input  in_valid, fc_result_0, fc_result_1, fc_result_2, fc_result_3, fc_result_4,
               fc_result_5, fc_result_6, fc_result_7, fc_result_8, fc_result_9, out_ready,
        output out_valid, classes, classes_b, max_score, margin, busy, overrun
    );

endinterface

// File: rtl/argmax_step.sv
// One scan step: folds a single lane score into the running (best, second, idx).
// Strict signed compares keep the earliest lane on ties.
module argmax_step
    import bnn_pkg::*;
#(
    parameter int SW = FC_SW
) (
    input  logic signed [SW-1:0]    lane,
    input  logic [IDX_W-1:0]        lane_idx,
    input  logic signed [SW-1:0]    best,
    input  logic signed [SW-1:0]    second,
    input  logic [IDX_W-1:0]        idx,
    output logic signed [SW-1:0]    best_n,
    output logic signed [SW-1:0]    second_n,
    output logic [IDX_W-1:0]        idx_n
);

    always_comb begin
        best_n   = best;
        second_n = second;
        idx_n    = idx;
        if (lane > best) begin
            second_n = best;
            best_n   = lane;
            idx_n    = lane_idx;
        end else if (lane > second) begin
            second_n = lane;
        end
    end

endmodule

// File: rtl/fc_argmax_seq.sv
// Sequential argmax over the ten FC lane scores: capture, scan one lane per cycle,
// then hold the winner (one-hot, binary, score, margin) until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for an in_valid strobe to capture a frame
// SCAN  | folding lanes 1..9 into best/second/idx, one per cycle
// HOLD  | result registers valid, waiting for out_ready
module fc_argmax_seq
    import bnn_pkg::*;
#(
    parameter int LANES = FC_LANES,
    parameter int SW    = FC_SW
) (
    input logic            clk,
    input logic            rstn,
    fc_argmax_seq_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

    state_t state, state_nx;
    logic   capture, step, load_out, accept, drop;

    logic signed [SW-1:0] score_buf [LANES];
    logic signed [SW-1:0] best, second, lane, best_n, second_n;
    logic [IDX_W-1:0]     idx, idx_n, cnt;
    logic [SW:0]          diff;

    always_comb begin
        lane = (cnt <= LAST) ? score_buf[cnt] : score_buf[0];
    end

    argmax_step #(.SW(SW)) u_step (
        .lane     (lane),
        .lane_idx (cnt),
        .best     (best),
        .second   (second),
        .idx      (idx),
        .best_n   (best_n),
        .second_n (second_n),
        .idx_n    (idx_n)
    );

    // Both operands sign-extended, so the difference is non-negative and fits SW+1 bits.
    assign diff = {best_n[SW-1], best_n} - {second_n[SW-1], second_n};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        step     = 1'b0;
        load_out = 1'b0;
        accept   = 1'b0;
        drop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    capture  = 1'b1;
                    state_nx = ST_SCAN;
                end
            end
            ST_SCAN: begin
                step = 1'b1;
                drop = bus.in_valid;
                if (cnt == LAST) begin
                    load_out = 1'b1;
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    accept = 1'b1;
                    if (bus.in_valid) begin
                        capture  = 1'b1;
                        state_nx = ST_SCAN;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    drop = bus.in_valid;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LANES; i++) score_buf[i] <= '0;
            best          <= '0;
            second        <= '0;
            idx           <= '0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.classes   <= '0;
            bus.classes_b <= '0;
            bus.max_score <= '0;
            bus.margin    <= '0;
            bus.busy      <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.overrun <= drop;
            bus.busy    <= (state_nx != ST_IDLE);
            if (capture) begin
                score_buf[0] <= bus.fc_result_0;
                score_buf[1] <= bus.fc_result_1;
                score_buf[2] <= bus.fc_result_2;
                score_buf[3] <= bus.fc_result_3;
                score_buf[4] <= bus.fc_result_4;
                score_buf[5] <= bus.fc_result_5;
                score_buf[6] <= bus.fc_result_6;
                score_buf[7] <= bus.fc_result_7;
                score_buf[8] <= bus.fc_result_8;
                score_buf[9] <= bus.fc_result_9;
                best         <= bus.fc_result_0;
                second       <= SCORE_MIN;
                idx          <= '0;
                cnt          <= IDX_W'(1);
            end else if (step) begin
                best   <= best_n;
                second <= second_n;
                idx    <= idx_n;
                cnt    <= cnt + IDX_W'(1);
            end
            if (load_out) begin
                bus.out_valid <= 1'b1;
                bus.classes   <= {{(LANES-1){1'b0}}, 1'b1} << idx_n;
                bus.classes_b <= idx_n;
                bus.max_score <= best_n;
                bus.margin    <= diff;
            end else if (accept) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fc_argmax_seq.sv
// Bench for fc_argmax_seq: directed score table, handshake corner sequences,
// and random frames checked against a simple first-max / max-of-rest model.
module tb_fc_argmax_seq;

    typedef struct packed {
        logic [9:0][9:0] s;
        logic [3:0]      idx;
        logic [9:0]      mx;
        logic [10:0]     mg;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    fc_argmax_seq_if #(.SW(10)) bus ();

    fc_argmax_seq dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                                input int a4, input int a5, input int a6, input int a7,
                                input int a8, input int a9, input int idx, input int mx,
                                input int mg);
        vec_t v;
        v.s[0] = a0[9:0]; v.s[1] = a1[9:0]; v.s[2] = a2[9:0]; v.s[3] = a3[9:0];
        v.s[4] = a4[9:0]; v.s[5] = a5[9:0]; v.s[6] = a6[9:0]; v.s[7] = a7[9:0];
        v.s[8] = a8[9:0]; v.s[9] = a9[9:0];
        v.idx = idx[3:0];
        v.mx  = mx[9:0];
        v.mg  = mg[10:0];
        return v;
    endfunction

    // Winner is the first maximum; second-best is the largest of all other lanes.
    function automatic void ref_model(input logic [9:0][9:0] sc, output int idx,
                                      output int mx, output int mg);
        int v[10];
        int sec;
        for (int k = 0; k < 10; k++) v[k] = int'($signed(sc[k]));
        idx = 0;
        for (int k = 1; k < 10; k++) if (v[k] > v[idx]) idx = k;
        mx  = v[idx];
        sec = -512;
        for (int k = 0; k < 10; k++) if (k != idx && v[k] > sec) sec = v[k];
        mg = mx - sec;
    endfunction

    task automatic drive_scores(input logic [9:0][9:0] sc);
        bus.fc_result_0 = sc[0]; bus.fc_result_1 = sc[1]; bus.fc_result_2 = sc[2];
        bus.fc_result_3 = sc[3]; bus.fc_result_4 = sc[4]; bus.fc_result_5 = sc[5];
        bus.fc_result_6 = sc[6]; bus.fc_result_7 = sc[7]; bus.fc_result_8 = sc[8];
        bus.fc_result_9 = sc[9];
    endtask

    // Strobe in_valid for the current cycle; returns #1 after the capturing edge.
    task automatic send(input logic [9:0][9:0] sc);
        drive_scores(sc);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts edges since the strobe cycle until out_valid; bounded.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 25) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic chk_result(input string tag, input int idx, input int mx, input int mg);
        chk({tag, " out_valid"}, int'(bus.out_valid), 1);
        chk({tag, " classes"},   int'(bus.classes), 1 << idx);
        chk({tag, " classes_b"}, int'(bus.classes_b), idx);
        chk({tag, " max_score"}, int'(bus.max_score), mx);
        chk({tag, " margin"},    int'(bus.margin), mg);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " out_valid"}, int'(bus.out_valid), 0);
        chk({tag, " classes"},   int'(bus.classes), 0);
        chk({tag, " classes_b"}, int'(bus.classes_b), 0);
        chk({tag, " max_score"}, int'(bus.max_score), 0);
        chk({tag, " margin"},    int'(bus.margin), 0);
        chk({tag, " busy"},      int'(bus.busy), 0);
        chk({tag, " overrun"},   int'(bus.overrun), 0);
    endtask

    vec_t tab[6];

    initial begin
        int lat, idx, mx, mg, tmp, dly, ov_cnt;
        logic [9:0][9:0] sc, sc2;
        logic [9:0] cls_hold;

        tab[0] = mk(5, -3, 12, 7, 12, 0, -512, 11, 1, 2, 2, 12, 0);
        tab[1] = mk(-512, -512, -512, -512, -512, -512, -512, -512, -512, -512, 0, -512, 0);
        tab[2] = mk(-1, -1, -1, -1, -1, -1, -1, -1, -1, 511, 9, 511, 512);
        tab[3] = mk(0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 1);
        tab[4] = mk(-512, -511, -300, 50, -7, 49, 0, 0, 0, 0, 3, 50, 1);
        tab[5] = mk(511, -512, -512, -512, -512, -512, -512, -512, -512, -512, 0, 511, 1023);

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive_scores('0);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed table with out_ready held high.
        for (int i = 0; i < 6; i++) begin
            send(tab[i].s);
            chk($sformatf("tab%0d busy", i), int'(bus.busy), 1);
            wait_out(lat);
            chk($sformatf("tab%0d latency", i), lat, 10);
            chk_result($sformatf("tab%0d", i), int'(tab[i].idx),
                       int'($signed(tab[i].mx)), int'(tab[i].mg));
            @(posedge clk); #1;
            chk($sformatf("tab%0d accepted", i), int'(bus.out_valid), 0);
            chk($sformatf("tab%0d idle", i), int'(bus.busy), 0);
        end

        // Stall with out_ready low, second strobe during HOLD is dropped.
        sc = tab[0].s;
        sc2 = tab[2].s;
        send(sc);
        bus.out_ready = 1'b0;
        wait_out(lat);
        chk("stall latency", lat, 10);
        cls_hold = bus.classes;
        ov_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            chk_result($sformatf("stall k%0d", k), 2, 12, 0);
            chk($sformatf("stall overrun k%0d", k), int'(bus.overrun), (k == 3) ? 1 : 0);
            if (bus.overrun) ov_cnt++;
            if (k == 2) drive_scores(sc2);
            bus.in_valid = (k == 2);
            @(posedge clk); #1;
        end
        chk("stall overrun count", ov_cnt, 1);
        chk("stall classes stable", int'(bus.classes), int'(cls_hold));
        bus.out_ready = 1'b1;
        chk_result("stall deliver", 2, 12, 0);
        @(posedge clk); #1;
        tmp = 0;
        for (int k = 0; k < 15; k++) begin
            if (bus.out_valid || bus.busy) tmp++;
            @(posedge clk); #1;
        end
        chk("stall no second result", tmp, 0);

        // Back-to-back: new strobe coincident with the accept.
        send(tab[3].s);
        wait_out(lat);
        chk("b2b first latency", lat, 10);
        chk_result("b2b first", 9, 9, 1);
        send(tab[4].s);
        chk("b2b no idle busy", int'(bus.busy), 1);
        chk("b2b accepted", int'(bus.out_valid), 0);
        wait_out(lat);
        chk("b2b second latency", lat, 10);
        chk_result("b2b second", 3, 50, 1);
        @(posedge clk); #1;

        // Reset asserted mid-SCAN.
        send(tab[5].s);
        repeat (4) @(posedge clk);
        #1;
        chk("rst busy before", int'(bus.busy), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_vals("midscan reset");
        @(posedge clk); #3;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("post reset");
        send(tab[0].s);
        wait_out(lat);
        chk("post reset latency", lat, 10);
        chk_result("post reset", 2, 12, 0);
        @(posedge clk); #1;

        // Random frames, some with narrow ranges to force ties, random accept delay.
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < 10; k++) begin
                if (f % 3 == 0) tmp = int'($urandom_range(0, 6)) - 3;
                else            tmp = int'($urandom);
                sc[k] = tmp[9:0];
            end
            ref_model(sc, idx, mx, mg);
            send(sc);
            wait_out(lat);
            chk($sformatf("rand%0d latency", f), lat, 10);
            chk_result($sformatf("rand%0d", f), idx, mx, mg);
            dly = int'($urandom_range(0, 2));
            if (dly > 0) begin
                bus.out_ready = 1'b0;
                repeat (dly) @(posedge clk);
                #1;
                chk($sformatf("rand%0d held", f), int'(bus.max_score), mx);
                bus.out_ready = 1'b1;
            end
            @(posedge clk); #1;
            chk($sformatf("rand%0d accepted", f), int'(bus.out_valid), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
